// File: rtl/systolic_output_deskewer_pkg.sv
// Shared types and helpers for the systolic output deskewer.
package systolic_output_deskewer_pkg;

    // Tile controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // LSB position of column 'col' inside a packed row of 'width'-bit columns.
    function automatic int col_lsb(input int col, input int width);
        return col * width;
    endfunction

endpackage

// File: rtl/systolic_output_deskewer_if.sv
// Bundle of control, systolic-array result and Unified Buffer write signals.
interface systolic_output_deskewer_if #(
    parameter int SA_COLS = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8
) ();
    logic                        start;
    logic [ADDR_W-1:0]           base_addr;
    logic [CNT_W-1:0]            num_rows;
    logic [SA_COLS-1:0]          SA_valid_in;
    logic [SA_COLS*DATA_W-1:0]   SA_data_in;
    logic                        ubuf_wr_en;
    logic [ADDR_W-1:0]           ubuf_wr_addr;
    logic [SA_COLS*DATA_W-1:0]   ubuf_wr_data;
    logic                        busy;
    logic                        done;
    logic                        err;

    // Producer side: controller and array drive the inputs, observe the results.
    modport master (
        output start, base_addr, num_rows, SA_valid_in, SA_data_in,
        input  ubuf_wr_en, ubuf_wr_addr, ubuf_wr_data, busy, done, err
    );

    // Deskewer side.
    modport slave (
        input  start, base_addr, num_rows, SA_valid_in, SA_data_in,
        output ubuf_wr_en, ubuf_wr_addr, ubuf_wr_data, busy, done, err
    );
endinterface

// File: rtl/systolic_output_deskewer_delay_line.sv
// Fixed-depth valid+data delay line; depth 0 is a plain wire.
module deskew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Last column needs no delay; clock and reset are intentionally unused.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0]  valid_reg;
            logic [DATA_W-1:0] data_reg [DEPTH];

            // Shift valid and data together every cycle; there is no stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_reg[i] <= '0;
                    end
                end else begin
                    valid_reg[0] <= in_valid;
                    data_reg[0]  <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                        data_reg[i]  <= data_reg[i-1];
                    end
                end
            end

            assign out_valid = valid_reg[DEPTH-1];
            assign out_data  = data_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_output_deskewer.sv
// Re-aligns the diagonally skewed systolic-array result stream into full rows
// and writes each row to consecutive Unified Buffer addresses.
module systolic_output_deskewer
    import systolic_output_deskewer_pkg::*;
#(
    parameter int SA_COLS = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_output_deskewer_if.slave bus
);

    localparam int                ROW_W    = SA_COLS * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [SA_COLS-1:0] dly_valid;
    logic [ROW_W-1:0]   dly_data;

    // Column j is held back SA_COLS-1-j cycles so every column of a row
    // reaches the alignment point together with the last column.
    genvar gi;
    generate
        for (gi = 0; gi < SA_COLS; gi++) begin : g_col
            localparam int LSB = col_lsb(gi, DATA_W);
            deskew_delay_line #(
                .DEPTH  (SA_COLS - 1 - gi),
                .DATA_W (DATA_W)
            ) u_delay (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (bus.SA_valid_in[gi]),
                .in_data   (bus.SA_data_in[LSB +: DATA_W]),
                .out_valid (dly_valid[gi]),
                .out_data  (dly_data[LSB +: DATA_W])
            );
        end
    endgenerate

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_ptr_reg;
    logic [CNT_W-1:0]  rows_left_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ROW_W-1:0]  wr_data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic row_aligned;
    logic row_mixed;
    logic can_write;
    logic start_accept;
    logic err_set;

    // A row may only be written while collecting and the tile still wants rows;
    // once the count is exhausted the controller spends one cycle closing the tile,
    // and an aligned row arriving then is as unexpected as one seen in IDLE/DONE.
    assign row_aligned  = &dly_valid;
    assign row_mixed    = (|dly_valid) && !row_aligned;
    assign can_write    = (state_reg == ST_COLLECT) && (rows_left_reg != '0);
    assign start_accept = (state_reg == ST_IDLE) && bus.start;
    assign err_set      = row_mixed || (row_aligned && !can_write);

    // Tile controller: start latching, row counting, busy and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_ptr_reg  <= '0;
            rows_left_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_ptr_reg  <= bus.base_addr;
                        rows_left_reg <= bus.num_rows;
                        if (bus.num_rows == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_COLLECT;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (rows_left_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if (row_aligned) begin
                        addr_ptr_reg  <= addr_ptr_reg + ADDR_ONE;
                        rows_left_reg <= rows_left_reg - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register for the aligned row; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= can_write && row_aligned;
            if (can_write && row_aligned) begin
                wr_addr_reg <= addr_ptr_reg;
                wr_data_reg <= dly_data;
            end
        end
    end

    // Sticky error flag; a new fault in the same cycle as an accepted start wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_set || (err_reg && !start_accept);
        end
    end

    assign bus.ubuf_wr_en   = wr_en_reg;
    assign bus.ubuf_wr_addr = wr_addr_reg;
    assign bus.ubuf_wr_data = wr_data_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.err          = err_reg;

endmodule

// File: tb/tb_systolic_output_deskewer.sv
// Randomized and directed tile scenarios checked against a row/tile-level model.
module tb_systolic_output_deskewer;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int CW   = 8;
    localparam int RW   = N * DW;
    localparam int L    = 48;
    localparam int MAXC = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_output_deskewer_if #(.SA_COLS(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    systolic_output_deskewer #(.SA_COLS(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            t;
        logic [N-1:0]  mask;
        logic [RW-1:0] data;
    } row_t;

    typedef struct {
        int            s;
        logic [AW-1:0] base;
        int            num;
    } start_t;

    row_t   rows[$];
    start_t starts[$];
    int     abort_c;

    // Per-cycle stimulus
    bit            s_rst   [MAXC];
    bit            s_start [MAXC];
    logic [AW-1:0] s_base  [MAXC];
    logic [CW-1:0] s_num   [MAXC];
    logic [N-1:0]  s_valid [MAXC];
    logic [RW-1:0] s_data  [MAXC];

    // Per-cycle expected outputs (as seen during that cycle)
    bit            e_wr    [MAXC];
    logic [AW-1:0] e_addr  [MAXC];
    logic [RW-1:0] e_data  [MAXC];
    bit            e_busy  [MAXC];
    bit            e_done  [MAXC];
    bit            e_err   [MAXC];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int scen     = 0;

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s scen=%0d cycle=%0d got=%h exp=%h", tag, scen, cyc, got, exp);
    endtask

    task automatic new_scenario();
        for (int c = 0; c < MAXC; c++) begin
            s_rst[c]   = 1'b0;
            s_start[c] = 1'b0;
            s_valid[c] = '0;
            s_data[c]  = RW'({$urandom, $urandom});
            s_base[c]  = AW'($urandom);
            s_num[c]   = CW'($urandom);
        end
        // Reset cycle with random junk on the inputs.
        s_rst[0]   = 1'b1;
        s_valid[0] = N'($urandom);
        s_start[0] = 1'($urandom_range(0, 1));
        rows.delete();
        starts.delete();
        abort_c = -1;
    endtask

    // Feed one row on the skewed schedule: column j appears j cycles after column 0.
    task automatic add_row(input int t, input logic [N-1:0] mask, input logic [RW-1:0] data);
        row_t r;
        r.t = t; r.mask = mask; r.data = data;
        rows.push_back(r);
        for (int j = 0; j < N; j++) begin
            if (mask[j]) begin
                s_valid[t+j][j]        = 1'b1;
                s_data[t+j][j*DW +: DW] = data[j*DW +: DW];
            end
        end
    endtask

    task automatic add_start(input int s, input logic [AW-1:0] base, input int num);
        start_t st;
        st.s = s; st.base = base; st.num = num;
        starts.push_back(st);
        s_start[s] = 1'b1;
        s_base[s]  = base;
        s_num[s]   = CW'(num);
    endtask

    // Tile-level reference: a row whose col-0 enters at t lines up at t+N-1 and is
    // written at t+N. Each accepted tile claims the first num complete rows that
    // line up after its start; every other complete or partial row is an error.
    task automatic build_expect();
        bit            set_e [MAXC];
        bit            clr_e [MAXC];
        bit            consumed [64];
        int            free_from, lim, lim_out, got, last_w, a, s, e;
        logic [AW-1:0] addr;
        for (int c = 0; c < MAXC; c++) begin
            e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
            e_addr[c] = '0; e_data[c] = '0; set_e[c] = 0; clr_e[c] = 0;
        end
        for (int i = 0; i < 64; i++) consumed[i] = 0;
        lim     = (abort_c >= 0) ? abort_c : L;
        lim_out = (abort_c >= 0) ? abort_c : L - 1;
        free_from = 1;
        foreach (starts[k]) begin
            s = starts[k].s;
            if (s < free_from || s >= lim) continue;
            clr_e[s+1] = 1;
            if (starts[k].num == 0) begin
                e_done[s+1] = 1;
                free_from = s + 2;
                continue;
            end
            got = 0; addr = starts[k].base; last_w = -1;
            for (int i = 0; i < rows.size(); i++) begin
                a = rows[i].t + N - 1;
                if (got < starts[k].num && !consumed[i] && rows[i].mask == {N{1'b1}} && a > s && a < lim) begin
                    consumed[i]  = 1;
                    e_wr[a+1]    = 1;
                    e_addr[a+1]  = addr;
                    e_data[a+1]  = rows[i].data;
                    addr         = addr + AW'(1);
                    got++;
                    last_w = a + 1;
                end
            end
            if (got == starts[k].num) begin
                for (int c = s + 1; c <= last_w; c++) e_busy[c] = 1;
                if (last_w + 1 <= lim_out) e_done[last_w+1] = 1;
                free_from = last_w + 2;
            end else begin
                for (int c = s + 1; c <= lim_out; c++) e_busy[c] = 1;
                free_from = MAXC;
            end
        end
        for (int i = 0; i < rows.size(); i++) begin
            a = rows[i].t + N - 1;
            if (a < lim && rows[i].mask != '0 && !consumed[i]) set_e[a+1] = 1;
        end
        e = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (abort_c >= 0 && c == abort_c + 1) e = 0;
            else if (set_e[c]) e = 1;
            else if (clr_e[c]) e = 0;
            e_err[c] = e;
        end
    endtask

    task automatic run_scenario();
        build_expect();
        for (int c = 0; c < L; c++) begin
            @(posedge clk);
            #1;
            rst             = s_rst[c];
            bus.start       = s_start[c];
            bus.base_addr   = s_base[c];
            bus.num_rows    = s_num[c];
            bus.SA_valid_in = s_valid[c];
            bus.SA_data_in  = s_data[c];
            @(negedge clk);
            cyc = c;
            if (c >= 1) begin
                check_val("wr_en", RW'(bus.ubuf_wr_en), RW'(e_wr[c]));
                if (e_wr[c]) begin
                    check_val("wr_addr", RW'(bus.ubuf_wr_addr), RW'(e_addr[c]));
                    check_val("wr_data", bus.ubuf_wr_data, e_data[c]);
                    $display("scen %0d cycle %0d write addr=%h data=%h", scen, c, bus.ubuf_wr_addr, bus.ubuf_wr_data);
                end
                check_val("busy", RW'(bus.busy), RW'(e_busy[c]));
                check_val("done", RW'(bus.done), RW'(e_done[c]));
                check_val("err",  RW'(bus.err),  RW'(e_err[c]));
            end
        end
        scen++;
    endtask

    initial begin
        logic [RW-1:0] d;
        logic [N-1:0]  mask;
        logic [AW-1:0] b;
        int            s0, num, t, nr;

        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
        bus.SA_valid_in = '0; bus.SA_data_in = '0;

        // Nominal tile: base 0x10, three back-to-back rows of 0x0100+r*4+j.
        new_scenario();
        add_start(2, 8'h10, 3);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(16'h0100 + r * 4 + j);
            add_row(4 + r, {N{1'b1}}, d);
        end
        run_scenario();

        // Address wrap from 0xFF to 0x00.
        new_scenario();
        add_start(1, 8'hFF, 2);
        add_row(3, {N{1'b1}}, RW'({$urandom, $urandom}));
        add_row(5, {N{1'b1}}, RW'({$urandom, $urandom}));
        run_scenario();

        // Empty tile; a start during the DONE cycle is ignored.
        new_scenario();
        add_start(2, AW'($urandom), 0);
        add_start(3, AW'($urandom), 1);
        run_scenario();

        // Column 2 dropped on row 1: rows 0 and 2 land at base, base+1.
        new_scenario();
        add_start(1, AW'($urandom), 3);
        add_row(3, {N{1'b1}}, RW'({$urandom, $urandom}));
        add_row(4, 4'b1011,   RW'({$urandom, $urandom}));
        add_row(5, {N{1'b1}}, RW'({$urandom, $urandom}));
        run_scenario();

        // Row in IDLE, then a tile with a second start mid-tile.
        new_scenario();
        b = AW'($urandom);
        add_row(1, {N{1'b1}}, RW'({$urandom, $urandom}));
        add_start(6, b, 2);
        add_row(8, {N{1'b1}}, RW'({$urandom, $urandom}));
        add_start(10, b + AW'(8'h40), 5);
        add_row(11, {N{1'b1}}, RW'({$urandom, $urandom}));
        run_scenario();

        // Reset after row 1 of 4.
        new_scenario();
        add_start(1, AW'($urandom), 4);
        add_row(3, {N{1'b1}}, RW'({$urandom, $urandom}));
        add_row(4, {N{1'b1}}, RW'({$urandom, $urandom}));
        abort_c = 12;
        s_rst[12] = 1'b1;
        run_scenario();

        // Random tiles.
        for (int k = 0; k < 20; k++) begin
            new_scenario();
            s0  = $urandom_range(1, 4);
            num = $urandom_range(0, 5);
            add_start(s0, AW'($urandom), num);
            t  = $urandom_range(1, s0 + 2);
            nr = num + $urandom_range(0, 1);
            for (int r = 0; r < nr; r++) begin
                if ($urandom_range(0, 9) < 8) mask = {N{1'b1}};
                else mask = N'($urandom_range(1, (1 << N) - 2));
                add_row(t, mask, RW'({$urandom, $urandom}));
                t += $urandom_range(1, 3);
            end
            if ($urandom_range(0, 1) == 1)
                add_start($urandom_range(s0 + 1, t + N + 2), AW'($urandom), $urandom_range(0, 2));
            run_scenario();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
